// File: rtl/control_cad.sv
// Channel-scan sequencer for a serial-output multiplexed ADC.
// Define CONTROL_CAD_CONT_SCAN_EN to rescan forever after one init.
module control_cad #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 8,
  parameter int ALE_CYC   = 1,
  parameter int START_CYC = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              init,
  input  logic              datain,
  input  logic              OE_R,
  output logic [2:0]        add,
  output logic              ALE,
  output logic              START,
  output logic [DATA_W-1:0] dataout,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, SETUP, LATCH, CONV, SHIFT, READY, RELEASE
  } state_t;

  localparam int M1   = (DATA_W > ALE_CYC) ? DATA_W : ALE_CYC;
  localparam int MAXC = (M1 > START_CYC) ? M1 : START_CYC;
  localparam int CW   = $clog2(MAXC) + 1;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic [2:0]        chan, chan_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [2:0]        add_n;
  logic              ale_n, start_n, busy_n;
  logic [DATA_W-1:0] data_n;
  logic              last_ch;

  assign last_ch = (chan == 3'(NUM_CH - 1));

  // Phase counter restarts on every state change
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      chan  <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : cnt + CW'(1);
      chan  <= chan_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n = state;
    chan_n  = chan;
    shreg_n = shreg;
    unique case (state)
      IDLE: begin
        if (init) begin
          state_n = SETUP;
          chan_n  = '0;
        end
      end
      SETUP: state_n = LATCH;
      LATCH: begin
        if (cnt == CW'(ALE_CYC - 1)) state_n = CONV;
      end
      CONV: begin
        if (cnt == CW'(START_CYC - 1)) state_n = SHIFT;
      end
      SHIFT: begin
        shreg_n = {shreg[DATA_W-2:0], datain};
        if (cnt == CW'(DATA_W - 1)) state_n = READY;
      end
      READY: begin
        if (OE_R) state_n = RELEASE;
      end
      RELEASE: begin
        if (!OE_R) begin
          if (last_ch) begin
            chan_n  = '0;
`ifdef CONTROL_CAD_CONT_SCAN_EN
            state_n = SETUP;
`else
            state_n = IDLE;
`endif
          end else begin
            chan_n  = chan + 3'd1;
            state_n = SETUP;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered
  always_comb begin
    ale_n   = 1'b0;
    start_n = 1'b0;
    busy_n  = 1'b1;
    unique case (state_n)
      IDLE:    busy_n  = 1'b0;
      LATCH:   ale_n   = 1'b1;
      CONV:    start_n = 1'b1;
      default: ;
    endcase
    add_n  = busy_n ? chan_n : 3'd0;
    data_n = (state == SHIFT && state_n == READY) ? shreg_n : dataout;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      add     <= '0;
      ALE     <= 1'b0;
      START   <= 1'b0;
      dataout <= '0;
      busy    <= 1'b0;
    end else begin
      add     <= add_n;
      ALE     <= ale_n;
      START   <= start_n;
      dataout <= data_n;
      busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_control_cad.sv
// Bench for control_cad: scripted ADC bit source and capture handshake.
// Expected words queue up as they are served and are popped at READY.
module tb_control_cad;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       init = 1'b0;
  logic       datain = 1'b0;
  logic       OE_R = 1'b0;
  logic [2:0] add;
  logic       ALE;
  logic       START;
  logic [7:0] dataout;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  control_cad dut (
    .CLK(CLK), .RST(RST), .init(init), .datain(datain), .OE_R(OE_R),
    .add(add), .ALE(ALE), .START(START), .dataout(dataout), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    OE_R = 1'b0;
    datain = 1'b0;
  endtask

  // Drive one conversion word; returns at the negedge after READY entry.
  task automatic serve(input logic [7:0] word, output bit ok,
                       output logic [2:0] ale_add);
    int n;
    ok = 1'b0;
    ale_add = 3'bxxx;
    n = 0;
    while (START !== 1'b1 && n < 40) begin
      if (ALE === 1'b1) ale_add = add;
      @(negedge CLK);
      n++;
    end
    if (START !== 1'b1) return;
    exp_q.push_back(word);
    @(negedge CLK);
    for (int i = 7; i >= 0; i--) begin
      datain = word[i];
      @(negedge CLK);
    end
    datain = 1'b0;
    ok = 1'b1;
  endtask

  function automatic logic [7:0] pop_exp();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    int bad;
    do_reset();
    vectors++;
    if (add !== 3'd0) begin
      miscompares++; $display("FAIL reset_add got %0d want 0", add);
    end
    vectors++;
    if (ALE !== 1'b0 || START !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulses got ALE=%b START=%b want 0/0", ALE, START);
    end
    vectors++;
    if (dataout !== 8'h00) begin
      miscompares++; $display("FAIL reset_dataout got %h want 00", dataout);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy got %b want 0", busy);
    end
    bad = 0;
    repeat (5) begin
      @(negedge CLK);
      if (busy !== 1'b0 || ALE !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL idle_hold got %0d busy cycles want 0", bad);
    end
  endtask

  task automatic test_single();
    logic [7:0] w, e;
    int partial;
    w = 8'hA5;
    init = 1'b1;
    @(negedge CLK);
    init = 1'b0;
    vectors++;
    if (busy !== 1'b1 || add !== 3'd0 || ALE !== 1'b0 || START !== 1'b0) begin
      miscompares++;
      $display("FAIL single_setup got busy=%b add=%0d ALE=%b START=%b want 1/0/0/0",
               busy, add, ALE, START);
    end
    @(negedge CLK);
    vectors++;
    if (ALE !== 1'b1 || START !== 1'b0 || add !== 3'd0) begin
      miscompares++;
      $display("FAIL single_latch got ALE=%b START=%b add=%0d want 1/0/0",
               ALE, START, add);
    end
    @(negedge CLK);
    vectors++;
    if (START !== 1'b1 || ALE !== 1'b0) begin
      miscompares++;
      $display("FAIL single_conv got START=%b ALE=%b want 1/0", START, ALE);
    end
    exp_q.push_back(w);
    @(negedge CLK);
    partial = 0;
    for (int i = 7; i >= 0; i--) begin
      datain = w[i];
      if (dataout !== 8'h00 || busy !== 1'b1) partial++;
      @(negedge CLK);
    end
    datain = 1'b0;
    vectors++;
    if (partial != 0) begin
      miscompares++;
      $display("FAIL single_partial got %0d early changes want 0", partial);
    end
    e = pop_exp();
    vectors++;
    if (dataout !== e || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_latency got %h busy=%b want %h busy=1", dataout, busy, e);
    end
    do_reset();
  endtask

  task automatic test_full_scan();
    logic [7:0] words[4];
    logic [7:0] e;
    logic [2:0] aa;
    bit ok;
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    init = 1'b1;
    @(negedge CLK);
    init = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      serve(words[ch], ok, aa);
      vectors++;
      if (!ok || aa !== 3'(ch)) begin
        miscompares++;
        $display("FAIL scan_add ch%0d got ok=%0d add=%0d want add=%0d", ch, ok, aa, ch);
      end
      e = pop_exp();
      vectors++;
      if (dataout !== e) begin
        miscompares++;
        $display("FAIL scan_ready ch%0d got %h want %h", ch, dataout, e);
      end
      OE_R = 1'b1;
      @(negedge CLK);
      vectors++;
      if (dataout !== e || add !== 3'(ch)) begin
        miscompares++;
        $display("FAIL scan_release ch%0d got %h add=%0d want %h add=%0d",
                 ch, dataout, add, e, ch);
      end
      @(negedge CLK);
      OE_R = 1'b0;
      @(negedge CLK);
    end
    vectors++;
`ifdef CONTROL_CAD_CONT_SCAN_EN
    if (add !== 3'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL scan_wrap got add=%0d busy=%b want 0/1", add, busy);
    end
`else
    if (add !== 3'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL scan_end got add=%0d busy=%b want 0/0", add, busy);
    end
`endif
    do_reset();
  endtask

  task automatic test_stall_then_reset();
    logic [7:0] e;
    logic [2:0] aa;
    bit ok;
    int bad;
    init = 1'b1;
    @(negedge CLK);
    init = 1'b0;
    serve(8'h5C, ok, aa);
    e = pop_exp();
    vectors++;
    if (!ok || dataout !== e) begin
      miscompares++; $display("FAIL stall_ready got %h ok=%0d want %h", dataout, ok, e);
    end
    bad = 0;
    repeat (50) begin
      @(negedge CLK);
      if (add !== 3'd0 || dataout !== e || ALE !== 1'b0 ||
          START !== 1'b0 || busy !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL stall_hold got %0d bad cycles want 0", bad);
    end
    OE_R = 1'b1;
    @(negedge CLK);
    OE_R = 1'b0;
    @(negedge CLK);
    vectors++;
    if (add !== 3'd1 || ALE !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_next got add=%0d ALE=%b busy=%b want 1/0/1", add, ALE, busy);
    end
    // Channel 1: abort on the 4th shift bit
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      datain = i[0];
      @(negedge CLK);
    end
    RST = 1'b1;
    @(negedge CLK);
    vectors++;
    if (busy !== 1'b0 || add !== 3'd0 || dataout !== 8'h00 ||
        ALE !== 1'b0 || START !== 1'b0) begin
      miscompares++;
      $display("FAIL abort got busy=%b add=%0d data=%h ALE=%b START=%b want all 0",
               busy, add, dataout, ALE, START);
    end
    RST = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (ALE !== 1'b0 || START !== 1'b0 || busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL abort_quiet got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_init_held();
    logic [7:0] words[4];
    logic [7:0] e;
    logic [2:0] aa;
    bit ok;
    words = '{8'hC3, 8'h0F, 8'hF0, 8'h96};
    init = 1'b1;
    @(negedge CLK);
    for (int ch = 0; ch < 4; ch++) begin
      serve(words[ch], ok, aa);
      e = pop_exp();
      vectors++;
      if (!ok || aa !== 3'(ch) || dataout !== e) begin
        miscompares++;
        $display("FAIL held_ch%0d got ok=%0d add=%0d data=%h want add=%0d data=%h",
                 ch, ok, aa, dataout, ch, e);
      end
      OE_R = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      OE_R = 1'b0;
      @(negedge CLK);
    end
    vectors++;
`ifdef CONTROL_CAD_CONT_SCAN_EN
    if (busy !== 1'b1 || add !== 3'd0) begin
      miscompares++;
      $display("FAIL held_end got busy=%b add=%0d want 1/0", busy, add);
    end
`else
    if (busy !== 1'b0 || add !== 3'd0) begin
      miscompares++;
      $display("FAIL held_end got busy=%b add=%0d want 0/0", busy, add);
    end
`endif
    @(negedge CLK);
    init = 1'b0;
    vectors++;
    if (busy !== 1'b1 || add !== 3'd0) begin
      miscompares++;
      $display("FAIL held_restart got busy=%b add=%0d want 1/0", busy, add);
    end
    serve(8'h3C, ok, aa);
    e = pop_exp();
    vectors++;
    if (!ok || aa !== 3'd0 || dataout !== e) begin
      miscompares++;
      $display("FAIL held_rescan got ok=%0d add=%0d data=%h want add=0 data=%h",
               ok, aa, dataout, e);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_scan();
    test_stall_then_reset();
    test_init_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_cad.md
Name: control_cad

Overview:
- Sequencer for a multiplexed serial-output ADC front end.
- Scans analog channels 0..NUM_CH-1. For each channel it drives the mux address, pulses ALE, then pulses START.
- After START it shifts in a DATA_W-bit serial result from datain and presents it on dataout. It then handshakes with the downstream capture logic over OE_R.
- It sits between the ADC pins and the register-capture block that latches one result per channel.

Parameters:
- NUM_CH, 4: number of channels scanned per init. Range 1..8.
- DATA_W, 8: conversion result width in bits.
- ALE_CYC, 1: ALE high time, in clocks (>=1).
- START_CYC, 1: START high time, in clocks (>=1).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- init  in  1  scan request; sampled only in IDLE.
- datain  in  1  serial ADC result bit, MSB first.
- OE_R  in  1  read strobe from the capture logic. High means dataout is being captured for the current add.
- add  out  3  ADC mux channel address.
- ALE  out  1  address-latch-enable pulse to the ADC.
- START  out  1  conversion start pulse to the ADC.
- dataout  out  DATA_W  last completed conversion result.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- One clock domain. RST is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, add=0, ALE=0, START=0, dataout=0, busy=0, channel counter=0, shift register=0.
- RST has priority over every other input. RST asserted mid-scan aborts to IDLE at the next edge with the reset values above.
- States: IDLE, SETUP, LATCH, CONV, SHIFT, READY, RELEASE.
- IDLE:
  - add=0.
  - On init=1 go to SETUP with channel=0.
  - init is ignored in every other state; it is level-sampled, not edge-detected.
- SETUP: 1 clock. add=channel, ALE=0, START=0. Next state LATCH.
- LATCH: ALE=1 for exactly ALE_CYC clocks, add stable. Next state CONV.
- CONV: START=1 for exactly START_CYC clocks, ALE=0. Next state SHIFT.
- SHIFT:
  - Exactly DATA_W clocks. Each edge does shreg = {shreg[DATA_W-2:0], datain}, so the first bit sampled is the MSB.
  - On the DATA_W-th edge, dataout is loaded with the complete word (including the last bit) and the state goes to READY.
  - dataout never shows partial words.
- READY:
  - Waits indefinitely for OE_R=1.
  - add and dataout hold.
  - On OE_R=1, go to RELEASE.
- RELEASE:
  - Waits for OE_R=0; add and dataout hold throughout.
  - On OE_R=0:
    - if channel==NUM_CH-1, go to IDLE (add returns to 0);
    - else channel+1 and go to SETUP.
- OE_R already high on entry to READY: READY takes one clock and moves to RELEASE. Capture is still counted exactly once per channel.
- Glitches in OE_R outside READY/RELEASE are ignored.
- Timing:
  - Per-channel latency from entering SETUP to dataout valid is 1+ALE_CYC+START_CYC+DATA_W clocks.
  - Default: 11 clocks.
- Channel counter wraps only through IDLE; add never exceeds NUM_CH-1.
- dataout keeps its last value in IDLE until overwritten by the next SHIFT completion.

Optional Feature:
- Macro: CONTROL_CAD_CONT_SCAN_EN.
- Defined: after releasing channel NUM_CH-1, the FSM goes straight to SETUP with channel=0, scanning continuously without a new init. It returns to IDLE only on RST.
- Undefined: one scan per init, then IDLE (the default behaviour above).

Test Plan:
1. Reset: RST=1 for 2 clocks -> add=0, ALE=0, START=0, dataout=0x00, busy=0. With init=0 afterwards, state stays IDLE.
2. Single channel timing (defaults):
   - Stimulus: init=1 for one clock.
   - Required: SETUP with add=0 for 1 clock; ALE=1 for 1 clock; START=1 for 1 clock.
   - Then datain carries bits 1,0,1,0,0,1,0,1 -> dataout=0xA5 exactly 11 clocks after SETUP entry; busy=1 throughout.
3. Full scan:
   - Serve 0x11, 0x22, 0x33, 0x44 on channels 0..3, pulsing OE_R high for 2 clocks after each READY.
   - Required: add steps 0,1,2,3; dataout matches per channel while OE_R=1; IDLE with add=0 after the 4th release.
4. Stalled handshake: hold OE_R=0 for 50 clocks in READY -> add and dataout unchanged, no ALE/START pulses. Then OE_R high then low -> next channel SETUP.
5. Reset mid-SHIFT: assert RST on the 4th shift bit -> next clock is IDLE, dataout=0x00, no further ALE/START.
6. init held high during a scan: no effect until IDLE. With CONTROL_CAD_CONT_SCAN_EN defined, after channel 3 is released add returns to 0 and ALE pulses again without init.
